md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO width in bits (legal values 8..64).
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, meaning the multiply latency in cycles (legal values 1..31).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, meaning the divide latency in cycles (legal values 1..31).
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-006 Port start, input, 1: operation request, sampled on the rising edge of clk.
REQ-007 Port op, input, 3: operation select; 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are no-ops.
REQ-008 Port src_a, input, WIDTH: multiplicand, dividend, or mthi/mtlo data.
REQ-009 Port src_b, input, WIDTH: multiplier or divisor.
REQ-010 Port busy, output, 1: a multiply or divide is in progress.
REQ-011 Port done, output, 1: one-cycle pulse; HI/LO have just been updated by a multiply or divide.
REQ-012 Port hi, output, WIDTH: HI register value.
REQ-013 Port lo, output, WIDTH: LO register value.

Function
REQ-014 A request SHALL be accepted when start=1 and busy=0 at a rising edge; src_a, src_b and op SHALL be captured internally at that edge.
REQ-015 A request with start=1 while busy=1 SHALL be ignored entirely; state, HI/LO and the countdown SHALL be unaffected.
REQ-016 States: IDLE (busy=0) and RUN (busy=1); an accepted mult, multu, div or divu SHALL move IDLE to RUN at edge k.
REQ-017 The countdown SHALL load N (MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu) at edge k and decrement once per cycle in RUN.
REQ-018 busy SHALL be 1 for exactly N cycles after edge k; at edge k+N, HI/LO SHALL be written, busy SHALL fall to 0, and done SHALL rise for exactly one cycle.
REQ-019 A new request SHALL be acceptable on the first cycle busy=0, so operations can run back-to-back with zero idle cycles.
REQ-020 Accepted mthi/mtlo SHALL write src_a into HI or LO respectively at the accepting edge; they SHALL not assert busy or done.
REQ-021 Accepted op 110/111 SHALL change nothing.
REQ-022 mult/multu SHALL form the full 2*WIDTH product (signed or unsigned respectively); HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 div/divu SHALL set LO = quotient and HI = remainder; signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero (div or divu) SHALL set LO = all ones and HI = dividend.
REQ-025 Signed overflow (div with dividend = most-negative value and divisor = -1) SHALL set LO = dividend and HI = 0.
REQ-026 Changes on src_a, src_b and op while busy=1 SHALL not affect the in-flight result.
REQ-027 The hi and lo outputs SHALL be driven directly from registers; during RUN they SHALL hold their previous values until edge k+N.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0 and countdown=0.
REQ-029 reset=0 SHALL take priority over start.
REQ-030 reset=0 during RUN SHALL abort the operation; no done pulse and no HI/LO write from the aborted operation SHALL occur afterwards.

Verification
REQ-031 Defaults; mult src_a=0xFFFFFFFD (-3), src_b=5 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulsed once.
REQ-032 divu 100/7, then div 0xFFFFFFF9 (-7) / 2 -> first lo=14, hi=2 after 10 cycles; second lo=0xFFFFFFFD, hi=0xFFFFFFFF with zero gap between operations.
REQ-033 div 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 mult 2*3 accepted; start=1 with mtlo 0xAAAA on cycle 2 of RUN -> ignored; final hi=0, lo=6.
REQ-035 mthi 0x55 then mtlo 0x66 on consecutive cycles -> hi=0x55, lo=0x66 one edge after each; busy and done stay 0.
REQ-036 div started, reset=0 on cycle 4 of RUN -> next cycle busy=0, hi=lo=0; no done pulse for the following 20 cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers.
// A fixed-latency countdown paces each multiply or divide; mthi/mtlo write HI/LO directly.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state  | meaning
    // S_IDLE | waiting for a request; mthi/mtlo/no-op handled here
    // S_RUN  | multiply or divide in flight, countdown running
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_cnt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_finish;
    logic                 w_ext_a;
    logic                 w_ext_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_dvsr;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (!op[2]) w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 5'd1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_op[0] set means the unsigned variant (multu/divu)
    always_comb begin
        w_ext_a  = r_op[0] ? 1'b0 : r_a[WIDTH-1];
        w_ext_b  = r_op[0] ? 1'b0 : r_b[WIDTH-1];
        w_prod   = {{WIDTH{w_ext_a}}, r_a} * {{WIDTH{w_ext_b}}, r_b};

        w_neg_a  = w_ext_a;
        w_neg_b  = w_ext_b;
        w_mag_a  = w_neg_a ? ('0 - r_a) : r_a;
        w_mag_b  = w_neg_b ? ('0 - r_b) : r_b;
        w_dvsr   = (r_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
        w_quo    = w_mag_a / w_dvsr;
        w_rem    = w_mag_a % w_dvsr;

        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_b == '0) begin
                w_res_lo = '1;
                w_res_hi = r_a;
            end else begin
                // most-negative / -1 wraps back to the dividend with zero remainder
                w_res_lo = (w_neg_a ^ w_neg_b) ? ('0 - w_quo) : w_quo;
                w_res_hi = w_neg_a ? ('0 - w_rem) : w_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_accept) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        r_op  <= op[1:0];
                        r_a   <= src_a;
                        r_b   <= src_b;
                        r_cnt <= op[1] ? DIV_N : MULT_N;
                    end
                    3'd4:    r_hi <= src_a;
                    3'd5:    r_lo <= src_a;
                    default: ;
                endcase
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases followed by random operations
// compared against an arithmetic reference model of HI/LO.
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO should become after an accepted operation
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                ps   = longint'(sa) * longint'(sb);
                m_hi = ps[63:32];
                m_lo = ps[31:0];
            end
            3'd1: begin
                pu   = {32'h0, a} * {32'h0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = '0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4:    m_hi = a;
            3'd5:    m_lo = a;
            default: ;
        endcase
    endtask

    // Runs one mult/div; while busy, start stays high with other requests that must be ignored
    task automatic do_md(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noisy);
        int           n;
        logic [W-1:0] ph;
        logic [W-1:0] pl;
        n  = o[1] ? DC : MC;
        ph = m_hi;
        pl = m_lo;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick;
        model(o, a, b);
        for (int c = 1; c <= n; c++) begin
            chk("busy_run", busy, 1);
            if (c == 1) chk("done_low_run", done, 0);
            if (c == 1 || c == n) begin
                chk("hi_hold", hi, ph);
                chk("lo_hold", lo, pl);
            end
            start = 1'b1;
            op    = noisy ? 3'($urandom) : 3'd5;
            src_a = noisy ? $urandom : 32'h0000_AAAA;
            src_b = $urandom;
            tick;
        end
        start = 1'b0;
        chk("busy_end", busy, 0);
        chk("done_pulse", done, 1);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [W-1:0] a);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = $urandom;
        tick;
        model(o, a, '0);
        start = 1'b0;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
        chk("mt_busy", busy, 0);
        chk("mt_done", done, 0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b0;
        start = 1'b0;
        op    = '0;
        src_a = '0;
        src_b = '0;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b1;
        tick;
        chk("idle_done", done, 0);

        do_md(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
        tick;
        chk("done_one_cycle", done, 0);

        do_md(3'd3, 32'd100, 32'd7, 1'b0);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);
        do_md(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);

        do_md(3'd2, 32'h1234_5678, 32'd0, 1'b1);
        chk("div0_hi", hi, 32'h1234_5678);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_lo", lo, 32'h8000_0000);

        do_md(3'd0, 32'd2, 32'd3, 1'b0);
        chk("ignore_mtlo_hi", hi, 32'd0);
        chk("ignore_mtlo_lo", lo, 32'd6);

        do_mt(3'd4, 32'h55);
        do_mt(3'd5, 32'h66);
        chk("mthi_val", hi, 32'h55);
        chk("mtlo_val", lo, 32'h66);
        do_mt(3'd6, 32'hDEAD_BEEF);
        do_mt(3'd7, 32'hCAFE_F00D);
        do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 32'd1;
                default: rb = $urandom;
            endcase
            if (ro < 3'd4) do_md(ro, ra, rb, 1'b1);
            else           do_mt(ro, ra);
        end

        start = 1'b1;
        op    = 3'd2;
        src_a = 32'd1000;
        src_b = 32'd3;
        tick;
        start = 1'b0;
        chk("abort_busy_before", busy, 1);
        tick;
        tick;
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, m_hi);
        chk("abort_lo", lo, m_lo);
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_done", done, 0);
            chk("abort_no_busy", busy, 0);
            tick;
        end
        chk("abort_hi_after", hi, 0);
        chk("abort_lo_after", lo, 0);

        do_mt(3'd4, 32'h1111_2222);
        reset = 1'b0;
        start = 1'b1;
        op    = 3'd0;
        src_a = 32'd7;
        src_b = 32'd9;
        tick;
        chk("prio_busy", busy, 0);
        chk("prio_hi", hi, 0);
        op = 3'd5;
        tick;
        chk("prio_lo", lo, 0);
        reset = 1'b1;
        start = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        do_md(3'd1, 32'd12, 32'd12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
